// File: rtl/rr_arb_pkg.sv
// Shared types and helper functions for the round-robin arbiter family.
// Widths are sized for the largest supported requester count and narrowed by the caller.
package rr_arb_pkg;

    localparam int MAX_N = 64;

    // One-hot vector with bit idx set; zero if idx is outside 0..n-1.
    function automatic logic [MAX_N-1:0] onehot(input int idx, input int n);
        logic [MAX_N-1:0] v;
        v = '0;
        if (idx >= 0 && idx < n && idx < MAX_N) begin
            v[idx] = 1'b1;
        end
        return v;
    endfunction

    // Rotate-right amount that puts the channel after ptr at bit 0.
    function automatic int rot_right_amt(input int ptr, input int n);
        return (ptr + 1) % n;
    endfunction

    // Rotate-left step that maps a rotated position back to a channel number.
    function automatic int rot_left_idx(input int pos, input int amt, input int n);
        return (pos + amt) % n;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first effective request strictly after ptr,
// wrapping, with the channel at ptr itself considered last.
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     ereq,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [N-1:0] rot;
    int           amt;
    int           pos;

    always_comb begin
        amt = rot_right_amt(int'(ptr), N);
        rot = '0;
        for (int i = 0; i < N; i++) begin
            rot[i] = ereq[(i + amt) % N];
        end

        // Fixed-priority, LSB first, on the rotated vector.
        found = 1'b0;
        pos   = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                pos   = i;
            end
        end

        idx = IDX_W'(rot_left_idx(pos, amt, N));
    end

endmodule

// File: rtl/rr_arbiter_hold.sv
// N-way round-robin arbiter with registered one-hot grant, bounded grant hold
// and per-channel masking; the rotation pointer survives idle periods.
module rr_arbiter_hold
    import rr_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 1,
    parameter int IDX_W    = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     req_mask,
    output logic [N-1:0]     gnt,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx
);

    localparam int HC_W = $clog2(MAX_HOLD + 1);

    generate
        if (N < 2 || N > MAX_N || MAX_HOLD < 1) begin : g_bad_params
            $error("rr_arbiter_hold: illegal parameters N=%0d MAX_HOLD=%0d", N, MAX_HOLD);
        end
    endgenerate

    logic [N-1:0]     ereq;
    logic [IDX_W-1:0] ptr;
    logic [HC_W-1:0]  hold_cnt;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             keep;

    logic [N-1:0]     gnt_nxt;
    logic             gnt_valid_nxt;
    logic [IDX_W-1:0] gnt_idx_nxt;
    logic [IDX_W-1:0] ptr_nxt;
    logic [HC_W-1:0]  hold_cnt_nxt;

    assign ereq = req & ~req_mask;

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .ereq  (ereq),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // The owner keeps the grant only while still effectively requesting and under budget.
    assign keep = gnt_valid && ereq[gnt_idx] && (int'(hold_cnt) < MAX_HOLD);

    always_comb begin
        gnt_nxt       = gnt;
        gnt_valid_nxt = gnt_valid;
        gnt_idx_nxt   = gnt_idx;
        ptr_nxt       = ptr;
        hold_cnt_nxt  = hold_cnt;

        if (keep) begin
            hold_cnt_nxt = hold_cnt + HC_W'(1);
        end else if (pick_found) begin
            gnt_nxt       = N'(onehot(int'(pick_idx), N));
            gnt_valid_nxt = 1'b1;
            gnt_idx_nxt   = pick_idx;
            ptr_nxt       = pick_idx;
            hold_cnt_nxt  = HC_W'(1);
        end else begin
            // Idle: ptr and gnt_idx deliberately keep their values.
            gnt_nxt       = '0;
            gnt_valid_nxt = 1'b0;
            hold_cnt_nxt  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
            ptr       <= IDX_W'(N - 1);
            hold_cnt  <= '0;
        end else begin
            gnt       <= gnt_nxt;
            gnt_valid <= gnt_valid_nxt;
            gnt_idx   <= gnt_idx_nxt;
            ptr       <= ptr_nxt;
            hold_cnt  <= hold_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert ($onehot0(gnt)) else $error("rr_arbiter_hold: gnt not one-hot");
            assert (int'(hold_cnt) <= MAX_HOLD) else $error("rr_arbiter_hold: hold_cnt overflow");
        end
    end

endmodule

// File: tb/tb_rr_arbiter_hold.sv
// Bench for rr_arbiter_hold: three instances (MAX_HOLD 3, 1, 4) on shared stimulus,
// a per-cycle reference model, and literal expectations from directed scenarios.
module tb_rr_arbiter_hold;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] req_mask;

    logic [3:0] d_gnt [3];
    logic       d_vld [3];
    logic [1:0] d_idx [3];

    int n_cmp  = 0;
    int n_fail = 0;
    bit live   = 1'b0;

    int mh    [3] = '{3, 1, 4};
    int m_own [3];
    int m_ptr [3];
    int m_cnt [3];
    int m_idx [3];

    always #5 clk = ~clk;

    rr_arbiter_hold #(.N(N), .MAX_HOLD(3)) u_h3 (
        .clk(clk), .reset(reset), .req(req), .req_mask(req_mask),
        .gnt(d_gnt[0]), .gnt_valid(d_vld[0]), .gnt_idx(d_idx[0]));

    rr_arbiter_hold #(.N(N), .MAX_HOLD(1)) u_h1 (
        .clk(clk), .reset(reset), .req(req), .req_mask(req_mask),
        .gnt(d_gnt[1]), .gnt_valid(d_vld[1]), .gnt_idx(d_idx[1]));

    rr_arbiter_hold #(.N(N), .MAX_HOLD(4)) u_h4 (
        .clk(clk), .reset(reset), .req(req), .req_mask(req_mask),
        .gnt(d_gnt[2]), .gnt_valid(d_vld[2]), .gnt_idx(d_idx[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: owner keeps while requesting and under budget, otherwise the
    // next requester after the last owner wins, otherwise idle.
    always @(posedge clk) begin
        for (int m = 0; m < 3; m++) begin
            if (reset) begin
                m_own[m] = -1;
                m_ptr[m] = N - 1;
                m_cnt[m] = 0;
                m_idx[m] = 0;
            end else begin
                logic [3:0] er;
                int win;
                er = req & ~req_mask;
                if (m_own[m] >= 0 && er[m_own[m]] && m_cnt[m] < mh[m]) begin
                    m_cnt[m] = m_cnt[m] + 1;
                end else begin
                    win = -1;
                    for (int k = 1; k <= N; k++) begin
                        if (win < 0 && er[(m_ptr[m] + k) % N]) win = (m_ptr[m] + k) % N;
                    end
                    if (win >= 0) begin
                        m_own[m] = win;
                        m_ptr[m] = win;
                        m_idx[m] = win;
                        m_cnt[m] = 1;
                    end else begin
                        m_own[m] = -1;
                        m_cnt[m] = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            for (int m = 0; m < 3; m++) begin
                logic [3:0] eg;
                eg = (m_own[m] < 0) ? 4'b0000 : (4'b0001 << m_own[m]);
                chk($sformatf("model_gnt[%0d]", m), 32'(d_gnt[m]), 32'(eg));
                chk($sformatf("model_vld[%0d]", m), 32'(d_vld[m]), 32'(m_own[m] >= 0));
                chk($sformatf("model_idx[%0d]", m), 32'(d_idx[m]), 32'(m_idx[m]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_g(input string name, input int m, input logic [3:0] g,
                            input logic v, input logic [1:0] i);
        chk({name, "_gnt"}, 32'(d_gnt[m]), 32'(g));
        chk({name, "_vld"}, 32'(d_vld[m]), 32'(v));
        chk({name, "_idx"}, 32'(d_idx[m]), 32'(i));
    endtask

    logic [3:0] rot3 [13] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010,
                              4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b1000,
                              4'b0001};

    initial begin
        reset    = 1'b1;
        req      = 4'b1111;
        req_mask = 4'b0000;

        // Reset held for two edges with everyone requesting.
        step();
        live = 1'b1;
        step();
        expect_g("reset", 0, 4'b0000, 1'b0, 2'd0);

        // Hold rotation with MAX_HOLD=3, then wrap to channel 0.
        reset = 1'b0;
        for (int e = 0; e < 13; e++) begin
            step();
            chk($sformatf("hold3_rot%0d", e), 32'(d_gnt[0]), 32'(rot3[e]));
        end

        // MAX_HOLD=1 alternates between the two requesters every cycle.
        reset = 1'b1;
        step();
        reset = 1'b0;
        req   = 4'b0011;
        for (int e = 0; e < 4; e++) begin
            step();
            chk($sformatf("hold1_alt%0d", e), 32'(d_gnt[1]), 32'((e % 2) ? 4'b0010 : 4'b0001));
        end

        // Early release, then a sole requester with no gap at hold expiry.
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        expect_g("early_own0", 0, 4'b0001, 1'b1, 2'd0);
        req = 4'b0010;
        step();
        expect_g("early_move1", 0, 4'b0010, 1'b1, 2'd1);
        req = 4'b0100;
        for (int e = 0; e < 8; e++) begin
            step();
            chk($sformatf("sole_ch2_%0d", e), 32'(d_gnt[0]), 32'(4'b0100));
        end

        // Pointer persists across idle.
        reset = 1'b1;
        step();
        reset = 1'b0;
        req   = 4'b0010;
        step();
        expect_g("idle_own1", 0, 4'b0010, 1'b1, 2'd1);
        req = 4'b0000;
        step();
        expect_g("idle_a", 0, 4'b0000, 1'b0, 2'd1);
        step();
        expect_g("idle_b", 0, 4'b0000, 1'b0, 2'd1);
        req = 4'b0110;
        step();
        expect_g("idle_resume", 0, 4'b0100, 1'b1, 2'd2);

        // Masking the owner mid-hold with MAX_HOLD=4, then a mid-operation reset.
        reset = 1'b1;
        step();
        reset = 1'b0;
        req   = 4'b0010;
        step();
        expect_g("mask_own1_c1", 2, 4'b0010, 1'b1, 2'd1);
        req = 4'b0011;
        step();
        expect_g("mask_own1_c2", 2, 4'b0010, 1'b1, 2'd1);
        req_mask = 4'b0010;
        step();
        expect_g("mask_move0", 2, 4'b0001, 1'b1, 2'd0);
        reset = 1'b1;
        step();
        expect_g("midreset", 2, 4'b0000, 1'b0, 2'd0);
        reset    = 1'b0;
        req_mask = 4'b0000;
        req      = 4'b1111;
        step();
        expect_g("post_reset", 2, 4'b0001, 1'b1, 2'd0);

        // Full mask forces idle on every instance.
        req_mask = 4'b1111;
        step();
        for (int m = 0; m < 3; m++) begin
            chk($sformatf("allmask_gnt%0d", m), 32'(d_gnt[m]), 32'(4'b0000));
            chk($sformatf("allmask_vld%0d", m), 32'(d_vld[m]), 32'(1'b0));
        end
        req_mask = 4'b0000;
        step();
        step();

        @(negedge clk);
        live = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
